// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: constants and state type shared by the transmit FIFO read and write sides.
package tx_fifo_pkg;
  localparam int DEPTH = 6;
  localparam int PTR_W = 3;
  localparam logic [PTR_W-1:0] PTR_MAX = 3'd5;
  localparam int DATA_W = 8;
  typedef enum logic {IDLE, LOADED} state_t;
endpackage

// File: rtl/fifo_flex_counter.sv
// fifo_flex_counter: counts 0..rollover_val then wraps to 0; clear has priority over enable.
module fifo_flex_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] r_count;
  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (count_enable) r_count <= rollover_flag ? '0 : r_count + 1'b1;
endmodule

// File: rtl/tx_fifo_read_ctrl.sv
// tx_fifo_read_ctrl: consumer end of the 6-entry TX FIFO; tail pointer, status flags and
// a one-byte prefetch register feeding the USB TX encoder.
module tx_fifo_read_ctrl
  import tx_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [PTR_W-1:0]  head_ptr,
  input  logic              head_tog,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              tx_get,
  output logic [PTR_W-1:0]  tail_ptr,
  output logic              tail_tog,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              empty,
  output logic              full,
  output logic [PTR_W-1:0]  count,
  output logic              underrun
);
  state_t            r_state, w_next;
  logic              r_tog, r_underrun;
  logic [DATA_W-1:0] r_data;
  logic [PTR_W-1:0]  w_tail;
  logic [PTR_W:0]    w_count;
  logic              w_load, w_wrap, w_same;

  fifo_flex_counter #(.NUM_CNT_BITS(PTR_W)) u_tail (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (w_load),
    .rollover_val (PTR_MAX),
    .count_out    (w_tail),
    .rollover_flag(w_wrap)
  );

  assign w_same  = (w_tail == head_ptr);
  assign empty   = w_same && (r_tog == head_tog);
  assign full    = w_same && (r_tog != head_tog);
  assign w_count = (r_tog == head_tog) ? {1'b0, head_ptr} - {1'b0, w_tail}
                                       : {1'b0, head_ptr} + (PTR_W+1)'(DEPTH) - {1'b0, w_tail};
  assign count   = w_count[PTR_W-1:0];

  // A load refills the output register whenever it is free or being consumed this edge.
  always_comb begin
    w_load = !clear && !empty && (r_state == IDLE || tx_get);
    w_next = r_state;
    if (clear) w_next = IDLE;
    else if (r_state == IDLE) w_next = empty ? IDLE : LOADED;
    else if (tx_get && empty) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state    <= IDLE;
      r_tog      <= 1'b0;
      r_data     <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tog      <= clear ? 1'b0 : r_tog ^ (w_load && w_wrap);
      r_data     <= w_load ? fifo_rdata : r_data;
      r_underrun <= !clear && r_state == IDLE && tx_get;
    end

  assign tail_ptr = w_tail;
  assign tail_tog = r_tog;
  assign tx_data  = r_data;
  assign tx_valid = (r_state == LOADED);
  assign underrun = r_underrun;
endmodule

// File: tb/tb_tx_fifo_read_ctrl.sv
// tb_tx_fifo_read_ctrl: directed bench with a behavioural storage array and write pointer.
module tb_tx_fifo_read_ctrl;
  logic       clk = 0, n_rst = 0, clear = 0, head_tog = 0, tx_get = 0;
  logic [2:0] head_ptr = 0;
  logic [7:0] fifo_rdata;
  logic [2:0] tail_ptr, count;
  logic       tail_tog, tx_valid, empty, full, underrun;
  logic [7:0] tx_data;
  logic [7:0] mem [0:7];
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign fifo_rdata = mem[tail_ptr];

  tx_fifo_read_ctrl dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .head_ptr(head_ptr), .head_tog(head_tog),
    .fifo_rdata(fifo_rdata), .tx_get(tx_get), .tail_ptr(tail_ptr), .tail_tog(tail_tog),
    .tx_data(tx_data), .tx_valid(tx_valid), .empty(empty), .full(full), .count(count),
    .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    mem[head_ptr] = b;
    if (head_ptr == 3'd5) begin
      head_ptr = 0;
      head_tog = ~head_tog;
    end else head_ptr = head_ptr + 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1;
    chk("rst_tail", tail_ptr, 0);
    chk("rst_tog", tail_tog, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_underrun", underrun, 0);
    // single byte, one-cycle latency
    write_byte(8'hA5);
    #1;
    chk("a5_empty", empty, 0);
    chk("a5_count", count, 1);
    chk("a5_valid_pre", tx_valid, 0);
    @(negedge clk);
    chk("a5_valid", tx_valid, 1);
    chk("a5_data", tx_data, 8'hA5);
    chk("a5_tail", tail_ptr, 1);
    chk("a5_count0", count, 0);
    tx_get = 1;
    @(negedge clk);
    tx_get = 0;
    chk("a5_drained", tx_valid, 0);
    chk("a5_stale", tx_data, 8'hA5);
    // fill storage to full with tx_get low
    for (int i = 0; i < 6; i++) begin
      write_byte(8'h10 + 8'(i));
      @(negedge clk);
    end
    chk("fill_valid", tx_valid, 1);
    chk("fill_data", tx_data, 8'h10);
    chk("fill_count5", count, 5);
    chk("fill_notfull", full, 0);
    write_byte(8'h16);
    #1;
    chk("fill_full", full, 1);
    chk("fill_count6", count, 6);
    @(negedge clk);
    chk("hold_data", tx_data, 8'h10);
    chk("hold_tail", tail_ptr, 2);
    tx_get = 1;
    for (int k = 0; k < 7; k++) begin
      chk("stream_valid", tx_valid, 1);
      chk("stream_data", tx_data, 8'h10 + 8'(k));
      @(negedge clk);
    end
    tx_get = 0;
    chk("stream_end_valid", tx_valid, 0);
    chk("stream_end_empty", empty, 1);
    chk("stream_end_tail", tail_ptr, 2);
    chk("stream_end_tog", tail_tog, 1);
    // underrun
    tx_get = 1;
    @(negedge clk);
    tx_get = 0;
    chk("ur_pulse", underrun, 1);
    chk("ur_tail", tail_ptr, 2);
    @(negedge clk);
    chk("ur_clear", underrun, 0);
    // clear with tx_get while loaded and storage holds 3
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h21 + 8'(i));
      @(negedge clk);
    end
    chk("cl_valid", tx_valid, 1);
    chk("cl_data", tx_data, 8'h21);
    chk("cl_tail", tail_ptr, 3);
    chk("cl_count", count, 3);
    clear = 1;
    tx_get = 1;
    @(negedge clk);
    clear = 0;
    tx_get = 0;
    head_ptr = 0;
    head_tog = 0;
    chk("cl_tail0", tail_ptr, 0);
    chk("cl_tog0", tail_tog, 0);
    chk("cl_valid0", tx_valid, 0);
    chk("cl_underrun", underrun, 0);
    chk("cl_data_kept", tx_data, 8'h21);
    #1;
    chk("cl_empty", empty, 1);
    // streaming at one byte per cycle, then async reset mid-stream
    tx_get = 1;
    for (int i = 0; i < 10; i++) begin
      write_byte(8'h30 + 8'(i));
      @(negedge clk);
    end
    chk("mid_tail", tail_ptr, 4);
    chk("mid_tog", tail_tog, 1);
    chk("mid_data", tx_data, 8'h39);
    tx_get = 0;
    #1 n_rst = 0;
    #1;
    chk("ar_tail", tail_ptr, 0);
    chk("ar_tog", tail_tog, 0);
    chk("ar_data", tx_data, 0);
    chk("ar_valid", tx_valid, 0);
    chk("ar_underrun", underrun, 0);
    head_ptr = 0;
    head_tog = 0;
    @(negedge clk);
    n_rst = 1;
    chk("ar_empty", empty, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_fifo_read_ctrl.md
# tx_fifo_read_ctrl

Read-side controller for the 6-entry transmit FIFO: maintains the tail pointer and its wrap toggle, derives empty/full/occupancy by comparing against the write side's head pointer and toggle, and prefetches one byte into a registered output stage for the USB TX encoder. It is the consumer end of the FIFO whose write end advances `head_ptr`/`head_tog`. Storage lives outside this block; this block drives only the read address and the output register.

## Interface
- DEPTH, 6, number of FIFO entries; pointers count 0..DEPTH-1.
- DATA_W, 8, byte width.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; asserted to write side in the same cycle.
- head_ptr  in  3  write pointer from write side.
- head_tog  in  1  write wrap toggle.
- fifo_rdata  in  DATA_W  storage entry addressed by tail_ptr, combinational.
- tx_get  in  1  encoder consumes current tx_data this cycle.
- tail_ptr  out  3  read pointer / storage read address.
- tail_tog  out  1  read wrap toggle.
- tx_data  out  DATA_W  registered byte presented to encoder.
- tx_valid  out  1  tx_data holds an unconsumed byte.
- empty  out  1  storage holds no entries (combinational).
- full  out  1  storage holds DEPTH entries (combinational).
- count  out  3  storage occupancy 0..6, excludes output register.
- underrun  out  1  registered one-cycle pulse: tx_get seen with tx_valid=0.

## Operation
- Reset: tail_ptr=0, tail_tog=0, tx_data=0, tx_valid=0, underrun=0, state IDLE.
- empty = (tail_ptr==head_ptr) && (tail_tog==head_tog); full = (tail_ptr==head_ptr) && (tail_tog!=head_tog).
- count = head_ptr-tail_ptr when toggles equal, else head_ptr+6-tail_ptr; computed 4 bits wide, truncated to 3.
- "Load": tx_data <= fifo_rdata, tail_ptr advances by 1; at tail_ptr==5 it wraps to 0 and tail_tog inverts in the same edge.
- FSM, two states, tx_valid = (state==LOADED):
  - IDLE: !empty -> load, go LOADED; else stay. tx_get here -> underrun pulse next cycle, no pointer change.
  - LOADED: tx_get && !empty -> load, stay LOADED (back-to-back). tx_get && empty -> go IDLE, tx_data holds stale value. !tx_get -> hold everything.
- clear has priority over all: next edge tail_ptr=0, tail_tog=0, tx_valid=0, state IDLE, underrun=0; tx_get in that cycle ignored; tx_data unchanged.
- Never advances tail when empty; tail can never pass head.

## Timing
- Head advance at edge N -> empty falls after N -> load at edge N+1 -> tx_valid=1 after N+1 (one-cycle latency).
- tx_get sampled at rising edge; consumed byte replaced at the same edge if storage non-empty, so sustained throughput is one byte per cycle.
- empty/full/count are combinational from current pointers; tail_ptr, tail_tog, tx_data, tx_valid, underrun are all registers.
- n_rst asserted mid-operation forces reset values immediately, independent of clk.

## Structure
- Package tx_fifo_pkg: DEPTH=6, PTR_W=3, PTR_MAX=3'd5, DATA_W=8, state enum {IDLE, LOADED}; shared with the write-side blocks.
- Tail pointer uses the existing fifo_flex_counter (NUM_CNT_BITS=3, rollover_val=PTR_MAX, clear=clear, count_enable=load); toggle register, compare logic, FSM and output register are local.

## Test plan
- Reset, head 0/0 -> tail 0/0, empty=1, full=0, count=0, tx_valid=0.
- Head steps 0->1 with byte 0xA5 at entry 0 -> one cycle later tx_valid=1, tx_data=0xA5, tail_ptr=1, count=0.
- Write six bytes 0x10..0x15 while tx_get held low -> first loaded; then head wraps to 0, head_tog=1, then write 0x16 -> full=1 only after sixth storage entry; tx_get every cycle -> 0x10..0x16 delivered on consecutive cycles, tail wraps 5->0 with tail_tog=1, ends empty=1, tx_valid=0.
- tx_get pulse with tx_valid=0 -> underrun=1 for exactly one cycle, tail unchanged.
- Storage count 3 with tx_valid=1, assert clear together with tx_get -> tail 0/0, tx_valid=0, no pointer advance from tx_get.
- n_rst pulsed low mid-stream (tail_ptr=4, tail_tog=1) -> all outputs return to reset values before next clk edge.
